// File: rtl/md_ctrl.sv
// md_ctrl: multiply/divide sequencer for the E stage.
// Owns the architectural HI/LO registers. Each start pulse launches one
// operation. A down-counter models the multi-cycle latency, and the result
// is committed to HI/LO when the counter expires.
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DIV
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       tmp_hi;
  logic [31:0]       tmp_lo;
  logic              div_zero;

  logic              is_mult;
  logic              is_div;
  logic              last_cycle;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [63:0]        product;

  logic               a_neg;
  logic               b_neg;
  logic [31:0]        a_mag;
  logic [31:0]        b_mag;
  logic [31:0]        divisor;
  logic [31:0]        q_mag;
  logic [31:0]        r_mag;
  logic [31:0]        quot;
  logic [31:0]        rem;

  assign is_mult    = (md_op == OP_MULT) || (md_op == OP_MULTU);
  assign is_div     = (md_op == OP_DIV)  || (md_op == OP_DIVU);
  assign last_cycle = (state != IDLE) && (cnt == CNT_W'(1));

  // busy also covers the launch cycle so the stall unit reacts immediately
  assign busy = (state != IDLE) | (start & (is_mult | is_div));

  // Both products are formed in parallel; md_op picks the signed or unsigned one
  assign prod_s  = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u  = {32'd0, A} * {32'd0, B};
  assign product = (md_op == OP_MULT) ? $unsigned(prod_s) : prod_u;

  // Signed division is done on magnitudes so truncation toward zero and the
  // remainder sign rules are explicit. The 0x80000000 / -1 overflow case then
  // yields 0x80000000 with remainder 0. A zero divisor is replaced by one only
  // to keep the divider well defined, because that result is never committed.
  assign a_neg   = (md_op == OP_DIV) & A[31];
  assign b_neg   = (md_op == OP_DIV) & B[31];
  assign a_mag   = a_neg ? (~A + 32'd1) : A;
  assign b_mag   = b_neg ? (~B + 32'd1) : B;
  assign divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag   = a_mag / divisor;
  assign r_mag   = a_mag % divisor;
  assign quot    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem     = a_neg ? (~r_mag + 32'd1) : r_mag;

  // State register; reset forces IDLE and aborts any operation in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start is only honoured from IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start && is_mult) begin
          state_next = MULT;
        end else if (start && is_div) begin
          state_next = DIV;
        end
      end
      MULT, DIV: begin
        if (cnt == CNT_W'(1)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch results at launch, count down, and commit HI/LO on the last cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt      <= '0;
      tmp_hi   <= '0;
      tmp_lo   <= '0;
      div_zero <= 1'b0;
      HI       <= '0;
      LO       <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        case (md_op)
          OP_MULT, OP_MULTU: begin
            tmp_hi   <= product[63:32];
            tmp_lo   <= product[31:0];
            cnt      <= CNT_W'(MULT_CYCLES);
            div_zero <= 1'b0;
          end
          OP_DIV, OP_DIVU: begin
            tmp_hi   <= rem;
            tmp_lo   <= quot;
            cnt      <= CNT_W'(DIV_CYCLES);
            div_zero <= (B == 32'd0);
          end
          OP_MTHI: HI <= A;
          OP_MTLO: LO <= A;
          default: ;
        endcase
      end
    end else begin
      cnt <= cnt - CNT_W'(1);
      if (last_cycle && !div_zero) begin
        HI <= tmp_hi;
        LO <= tmp_lo;
      end
    end
  end

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Multiply/divide sequencer for the E stage; owns the architectural HI/LO registers.
- Accepts one operation per start pulse, models multi-cycle latency with a down-counter, and commits results to HI/LO on completion.
- Drives busy to the stall unit, which stalls D-stage mult/div/mthi/mtlo/mfhi/mflo while busy is high.

Parameters:
- MULT_CYCLES, 5, busy cycles in state MULT for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles in state DIV for div/divu (>=1).

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-low reset
- start  input  1  E-stage instruction is an MD-class op, qualified by md_op
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- A  input  32  rs operand (forwarded)
- B  input  32  rt operand (forwarded)
- busy  output  1  MD resource occupied
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is synchronous and active-low: sampled low at a rising edge forces state=IDLE, cnt=0, HI=0, LO=0, temp regs=0.
  - busy is 0 in the cycle after reset.
  - Reset wins over a simultaneous start.
  - Reset mid-operation aborts it; no HI/LO commit.
- States: IDLE, MULT, DIV. cnt is a down-counter, width ceil(log2(max(MULT_CYCLES,DIV_CYCLES)+1)).
- IDLE with start=1:
  - md_op 1/2: compute the 64-bit product now, latch it into tmp_hi/tmp_lo, cnt<=MULT_CYCLES, go to MULT.
  - md_op 3/4: latch quotient into tmp_lo and remainder into tmp_hi, cnt<=DIV_CYCLES, go to DIV.
  - md_op 5: HI<=A at this edge, stay IDLE.
  - md_op 6: LO<=A at this edge, stay IDLE.
  - md_op 0/7: no effect.
- MULT/DIV:
  - Each edge cnt<=cnt-1.
  - At the edge where cnt==1: HI<=tmp_hi, LO<=tmp_lo, go to IDLE.
  - start is ignored while in MULT/DIV (the stall unit guarantees none arrives; mthi/mtlo included).
- busy (combinational):
  - busy = (state!=IDLE) | (start & md_op in {1,2,3,4}).
  - A mult started in cycle t is busy for cycles t..t+MULT_CYCLES.
  - New HI/LO is visible from cycle t+MULT_CYCLES+1. DIV is analogous.
  - mthi/mtlo never raise busy; the new value is visible the cycle after start.
- Arithmetic:
  - mult: signed 32x32 -> 64 two's complement.
  - multu: unsigned.
  - HI = product[63:32], LO = product[31:0].
  - div: signed, quotient truncates toward zero, remainder takes the sign of the dividend.
  - divu: unsigned.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
  - Divide by zero (B==0, div or divu): the operation still occupies DIV_CYCLES busy cycles, but HI/LO stay unchanged at commit.
- Back-to-back: a new start is accepted in the first cycle state==IDLE after commit. It then sees the committed HI/LO; the next start has no effect on them until its own commit.

Test Plan:
- Reset: hold reset=0 two cycles with start=1, md_op=1 -> busy=0, HI=0, LO=0 after release; no commit ever occurs.
- Signed mult: A=0xFFFFFFFF, B=2, md_op=1 at cycle 0 -> busy=1 cycles 0..5, HI/LO unchanged through cycle 5; cycle 6 HI=0xFFFFFFFF, LO=0xFFFFFFFE. Same operands with multu -> HI=0x00000001, LO=0xFFFFFFFE.
- Signed div: A=0xFFFFFFF9 (-7), B=2, md_op=3 -> busy cycles 0..10; cycle 11 LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 -> LO=3, HI=1. Overflow case 0x80000000 / 0xFFFFFFFF signed -> LO=0x80000000, HI=0.
- Divide by zero: preload HI=0x11, LO=0x22 via mthi/mtlo; div with B=0 -> busy for 11 cycles; HI=0x11, LO=0x22 afterwards.
- mthi/mtlo and ignore-while-busy: mthi A=0xABCD -> HI=0xABCD next cycle, busy never 1. Start mult; at cycle 2 pulse start with md_op=6, A=0x55 -> ignored; LO equals the product at commit, not 0x55.
- Reset mid-op: start div, drive reset=0 at cycle 4 -> busy=0 at cycle 5, HI=LO=0, no later commit. Back-to-back: mult committing at cycle 6, new div start at cycle 6 accepted, busy stays 1 continuously through cycle 16.
